pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage in-order core.
- Drives the stall/flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three hazard sources:
  - load-use dependencies,
  - taken branches/jumps resolved in EX,
  - multi-cycle events: data-memory wait and MDU busy.
- Small FSM tracks the multi-cycle events; perf counters record stall and flush cycles.
- Sits in the core top between decode/EX/MEM status signals and the pipeline registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose: shared encodings for the pipeline hazard sequencer (opcodes, NOP, FSM states, control vector).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: OP_LOAD / OP_I_IMM opcodes, canonical NOP, 2-bit FSM state codes, packed
//           stall/flush control vector and the fixed patterns driven onto it.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_I_IMM = 7'b0010011;
  // ADDI x0,x0,0: what ID_EX carries when it is flushed.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MDU_BUSY = 2'd2;

  // Field order fixes the bit order of the patterns below (MSB first).
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE     = 8'b0000_0000;
  localparam hz_ctrl_t CTRL_RESET    = 8'b0010_1011; // every flush, no stall
  localparam hz_ctrl_t CTRL_MEM_WAIT = 8'b1101_0101; // freeze PC..EX_MEM, bubble into WB
  localparam hz_ctrl_t CTRL_BRANCH   = 8'b0010_1000; // squash IF_ID and ID_EX
  localparam hz_ctrl_t CTRL_MDU      = 8'b1101_0010; // freeze PC..ID_EX, bubble into MEM
  localparam hz_ctrl_t CTRL_LOAD_USE = 8'b1100_1000; // hold fetch/decode, one bubble into EX

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Purpose: combinational load-use comparator between the ID source operands and a load in EX.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
// Ports: id_rs*_re/addr (ID operand reads), ex_opcode/ex_rd_we/ex_rd_addr (EX producer),
//        load_use (1 when the ID instruction needs the EX load's result).
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       id_rs1_re,
  input  logic [4:0] id_rs1_addr,
  input  logic       id_rs2_re,
  input  logic [4:0] id_rs2_addr,
  input  logic [6:0] ex_opcode,
  input  logic       ex_rd_we,
  input  logic [4:0] ex_rd_addr,
  output logic       load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign ex_is_load = (ex_opcode == OP_LOAD) && ex_rd_we && (ex_rd_addr != 5'd0);
  assign rs1_hit    = id_rs1_re && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit    = id_rs2_re && (id_rs2_addr == ex_rd_addr);
  assign load_use   = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: central stall/flush sequencer for the 5-stage core (load-use, taken branch, mem wait, MDU).
// Latency: stall/flush outputs are combinational from state + inputs; state/counters update on posedge clk.
// Backpressure: memory wait and MDU busy hold the front of the pipe until mem_ready / mdu_done.
// Ports: ID/EX/MEM hazard status in; per-register stall/flush out; sticky mdu_timeout;
//        perf counters stall_cycles (pc_stall cycles) and flush_events (if_id_flush cycles).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_rs1_re,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs2_re,
  input  logic [4:0]       id_rs2_addr,
  input  logic [6:0]       ex_opcode,
  input  logic             ex_rd_we,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int TO_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  hz_ctrl_t         ctl;
  logic             load_use;
  logic             mem_wait;

  hazard_detect u_hazard_detect (
    .id_rs1_re   (id_rs1_re),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_re   (id_rs2_re),
    .id_rs2_addr (id_rs2_addr),
    .ex_opcode   (ex_opcode),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .load_use    (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    ctl       = CTRL_NONE;
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          ctl     = CTRL_MEM_WAIT;
          state_d = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          // The dependent instruction is squashed, so a concurrent load-use needs no bubble.
          ctl = CTRL_BRANCH;
        end else if (ex_mdu_start) begin
          ctl       = CTRL_MDU;
          state_d   = ST_MDU_BUSY;
          mdu_cnt_d = '0;
        end else if (load_use) begin
          ctl = CTRL_LOAD_USE;
        end
      end
      ST_MEM_WAIT: begin
        // Held purely by the memory; the ready cycle itself lets the pipe advance.
        if (!mem_ready) ctl = CTRL_MEM_WAIT;
        else            state_d = ST_RUN;
      end
      ST_MDU_BUSY: begin
        // A memory wait widens the freeze to EX_MEM, replacing the MEM bubble.
        if (mem_wait)       ctl = CTRL_MEM_WAIT;
        else if (!mdu_done) ctl = CTRL_MDU;
        if (mdu_done) begin
          state_d = mem_wait ? ST_MEM_WAIT : ST_RUN;
        end else if (mdu_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = mem_wait ? ST_MEM_WAIT : ST_RUN;
        end else begin
          mdu_cnt_d = mdu_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Reset drives the pipe to a bubble-filled, free-running state without waiting for a clock.
    if (!rst_n) ctl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      timeout_q <= timeout_d;
      if (ctl.pc_stall)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ctl.if_id_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign pc_stall     = ctl.pc_stall;
  assign if_id_stall  = ctl.if_id_stall;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_stall  = ctl.id_ex_stall;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_stall = ctl.ex_mem_stall;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;
  assign mdu_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed scoreboard bench for pipe_hazard_ctrl (MDU_TIMEOUT=8).
// Latency: one vector per clock; expected entry pushed at drive time, checked at the following negedge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // Output vector bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush.
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_RST  = 8'b0010_1011;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_MW   = 8'b1101_0101;
  localparam logic [7:0] O_MDU  = 8'b1101_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_rs1_re = 1'b0, id_rs2_re = 1'b0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic [6:0]  ex_opcode = OP_I_IMM;
  logic        ex_rd_we = 1'b0, ex_branch_taken = 1'b0, ex_mdu_start = 1'b0;
  logic        mdu_done = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_timeout;
  logic [31:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.CNT_W(32), .MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
    .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
    .ex_opcode(ex_opcode), .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_timeout(mdu_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] o;
    logic       to;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  // Drives one cycle of inputs just after the rising edge and queues the expected response.
  task automatic vec(input string nm, input logic rst,
                     input logic [6:0] opc, input logic rd_we, input logic [4:0] rd,
                     input logic rs1_re, input logic [4:0] rs1,
                     input logic rs2_re, input logic [4:0] rs2,
                     input logic br, input logic ms, input logic md,
                     input logic mreq, input logic mrdy,
                     input logic [7:0] eo, input logic eto);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst; ex_opcode = opc; ex_rd_we = rd_we; ex_rd_addr = rd;
    id_rs1_re = rs1_re; id_rs1_addr = rs1; id_rs2_re = rs2_re; id_rs2_addr = rs2;
    ex_branch_taken = br; ex_mdu_start = ms; mdu_done = md;
    mem_req = mreq; mem_ready = mrdy;
    if (!rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end
    x.nm = nm; x.o = eo; x.to = eto; x.sc = exp_sc; x.fc = exp_fc;
    q.push_back(x);
    if (rst) begin
      exp_sc += int'(eo[7]);
      exp_fc += int'(eo[5]);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, ex_mem_flush, mem_wb_flush} !== e.o ||
          mdu_timeout !== e.to || stall_cycles !== 32'(e.sc) || flush_events !== 32'(e.fc)) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b to=%b stalls=%0d flushes=%0d, expected ctl=%b to=%b stalls=%0d flushes=%0d",
                 e.nm, {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_flush}, mdu_timeout, stall_cycles,
                 flush_events, e.o, e.to, e.sc, e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //   name            rst opc       we rd rs1e rs1 rs2e rs2 br ms md mreq mrdy  out     to
    vec("rst_a",          0, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0);
    vec("rst_b",          0, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0);
    vec("idle",           1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("lu_rs1",         1, OP_LOAD,  1, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, O_LU,   0);
    vec("lu_bubble",      1, OP_I_IMM, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("lu_rs2",         1, OP_LOAD,  1, 7, 0, 0, 1, 7, 0, 0, 0, 0, 0, O_LU,   0);
    vec("lu_rs2_noread",  1, OP_LOAD,  1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("lu_rd_x0",       1, OP_LOAD,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("lu_no_we",       1, OP_LOAD,  0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("lu_not_load",    1, OP_I_IMM, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("br_over_lu",     1, OP_LOAD,  1, 5, 1, 5, 0, 0, 1, 0, 0, 0, 0, O_BR,   0);
    vec("br_only",        1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_BR,   0);
    vec("mem_hit",        1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE, 0);
    vec("mw_1_over_br",   1, OP_LOAD,  1, 5, 1, 5, 0, 0, 1, 0, 0, 1, 0, O_MW,   0);
    vec("mw_2_ignore",    1, OP_LOAD,  1, 5, 1, 5, 0, 0, 1, 1, 0, 1, 0, O_MW,   0);
    vec("mw_3_ignore",    1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, O_MW,   0);
    vec("mw_ready",       1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE, 0);
    vec("mw_back_run",    1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_BR,   0);
    vec("mdu_start_lu",   1, OP_LOAD,  1, 5, 1, 5, 0, 0, 0, 1, 0, 0, 0, O_MDU,  0);
    for (int i = 0; i < 5; i++)
      vec("mdu_busy",     1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MDU,  0);
    vec("mdu_done",       1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE, 0);
    vec("mdu_after",      1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("mdu2_start",     1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MDU,  0);
    vec("mdu2_memwait",   1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MW,   0);
    vec("mdu2_busy",      1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MDU,  0);
    vec("mdu2_done",      1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE, 0);
    vec("to_start",       1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MDU,  0);
    for (int i = 0; i < 8; i++)
      vec("to_busy",      1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MDU,  0);
    vec("to_run",         1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 1);
    vec("to_sticky_br",   1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_BR,   1);
    vec("mdu3_start",     1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MDU,  1);
    vec("mdu3_busy",      1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MDU,  1);
    vec("arst_mid_busy",  0, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0);
    vec("arst_release",   1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    vec("post_rst_br",    1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_BR,   0);
    vec("post_rst_idle",  1, OP_I_IMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
